// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds FSM encoding, buffer depth, default reset PC and instruction width.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          BUF_DEPTH        = 2;
  localparam int          CNT_W            = 2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } buf_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// 2-entry {pc, instr} FIFO: push visible at head next cycle, push+pop when full keeps both.
// Push while full without pop and pop while empty are ignored; flush empties it at the edge.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  buf_entry_t       push_dat,
  output buf_entry_t       head_dat,
  output logic [CNT_W-1:0] count
);

  buf_entry_t       ent0_q, ent0_d;
  buf_entry_t       ent1_q, ent1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_en;
  logic             push_en;
  logic [CNT_W-1:0] count_after_pop;

  always_comb begin
    ent0_d          = ent0_q;
    ent1_d          = ent1_q;
    count_d         = count_q;
    pop_en          = pop && (count_q != '0);
    push_en         = push && ((count_q != CNT_W'(BUF_DEPTH)) || pop_en);
    count_after_pop = count_q - CNT_W'(pop_en);
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop_en) begin
        ent0_d = ent1_q;
      end
      // new entry lands in the first free slot after the head has shifted
      if (push_en) begin
        if (count_after_pop == '0) begin
          ent0_d = push_dat;
        end else begin
          ent1_d = push_dat;
        end
      end
      count_d = count_after_pop + CNT_W'(push_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_dat = (count_q != '0) ? ent0_q : '0;
  assign count    = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: BOOT/RUN/HALTED FSM, fetch_pc, 2-entry buffer; 1-cycle fetch-to-valid, out_ready pops.
// Redirect flushes and wins over push/pop/halt; optional counters under FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_redirect_cnt
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] buf_count;
  buf_entry_t       head;
  buf_entry_t       push_dat;
  logic             pop_en;
  logic             push_en;
  logic             buf_full;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign buf_full  = (buf_count == CNT_W'(BUF_DEPTH));
  assign out_valid = (buf_count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign imem_addr = fetch_pc_q;
  assign pop_en    = out_valid && out_ready && !redirect_valid;
  assign push_dat  = '{pc: fetch_pc_q, instr: imem_instr};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push_en    = 1'b0;
    // a redirect cycle only reloads the PC; the state holds
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      case (state_q)
        ST_BOOT: state_d = halt ? ST_HALTED : ST_RUN;
        ST_RUN: begin
          push_en = !buf_full || pop_en;
          if (push_en) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
          if (halt) begin
            state_d = ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (!halt) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push_en),
    .pop      (pop_en),
    .flush    (redirect_valid),
    .push_dat (push_dat),
    .head_dat (head),
    .count    (buf_count)
  );

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if ((state_q == ST_RUN) && buf_full && !pop_en) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect_valid) begin
      redir_cnt_d = redir_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_redirect_cnt = redir_cnt_q;
`else
  assign perf_stall_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: queue-based reference model, randomized traffic plus directed scenarios.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, halt, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, out_pc, out_instr, perf_stall_cnt, perf_redirect_cnt;
  logic        out_valid;

  logic        rst2;
  logic [31:0] imem_addr2, imem_instr2, out_pc2, out_instr2, perf_stall2, perf_redir2;
  logic        out_valid2;

  int checks   = 0;
  int failures = 0;

  ent_t        mbuf[$];
  ent_t        exp_q[$];
  logic [31:0] m_pc;
  int          m_st;
  logic [31:0] m_stall, m_redir;
  bit          model_live = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr  = rom(imem_addr);
  assign imem_instr2 = rom(imem_addr2);

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_pc(out_pc2), .out_instr(out_instr2),
    .perf_stall_cnt(perf_stall2), .perf_redirect_cnt(perf_redir2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: advances once per rising edge from the inputs held over the previous cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_st = M_BOOT; m_pc = 32'h0; m_stall = 0; m_redir = 0;
        mbuf.delete(); exp_q.delete();
        model_live = 1'b1;
      end else if (model_live) begin
        bit pop;
        int sz;
        sz  = mbuf.size();
        pop = (sz > 0) && out_ready && !redirect_valid;
        if (m_st == M_RUN && sz == 2 && !pop) m_stall = m_stall + 1;
        if (redirect_valid) begin
          mbuf.delete(); exp_q.delete();
          m_pc    = {redirect_pc[31:2], 2'b00};
          m_redir = m_redir + 1;
        end else begin
          if (pop) void'(mbuf.pop_front());
          if (m_st == M_RUN && (sz < 2 || pop)) begin
            ent_t e;
            e.pc = m_pc; e.instr = rom(m_pc);
            mbuf.push_back(e);
            exp_q.push_back(e);
            m_pc = m_pc + 32'd4;
          end
          m_st = halt ? M_HALT : M_RUN;
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires scoreboard entries on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, mbuf.size() != 0});
        chk("imem_addr", imem_addr, m_pc);
        chk("perf_stall", perf_stall_cnt, PERF ? m_stall : 32'h0);
        chk("perf_redirect", perf_redirect_cnt, PERF ? m_redir : 32'h0);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL head_empty actual=valid expected=no_entry at %0t", $time);
          end else begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_instr", out_instr, exp_q[0].instr);
            if (out_ready && !redirect_valid && !rst) void'(exp_q.pop_front());
          end
        end else begin
          chk("out_pc_idle", out_pc, 32'h0);
          chk("out_instr_idle", out_instr, 32'h0);
        end
      end
    end
  end

  initial begin
    logic [31:0] exp2 [3];
    int n2;
    int first_valid;
    exp2 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1; rst2 = 1'b1;
    cyc(2);
    rst = 1'b0; cyc(8);
    out_ready = 1'b0; cyc(5); out_ready = 1'b1; cyc(2);
    out_ready = 1'b0; cyc(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013; cyc(1);
    redirect_valid = 1'b0; cyc(1); out_ready = 1'b1; cyc(3);
    out_ready = 1'b0; cyc(3); halt = 1'b1; out_ready = 1'b1; cyc(4); halt = 1'b0; cyc(4);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF6; cyc(1); redirect_valid = 1'b0; cyc(5);
    out_ready = 1'b0; cyc(3);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; cyc(1);
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1; cyc(4);

    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      out_ready      = ($urandom_range(0, 9) < 7);
      cyc(1);
    end
    rst = 1'b0; redirect_valid = 1'b0; halt = 1'b0; out_ready = 1'b1;
    cyc(6);

    rst2 = 1'b0;
    n2 = 0; first_valid = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid2 && n2 < 3) begin
        if (first_valid < 0) first_valid = k;
        chk("wrap_out_pc", out_pc2, exp2[n2]);
        chk("wrap_out_instr", out_instr2, rom(exp2[n2]));
        n2++;
      end
    end
    chk("wrap_first_valid_cycle", first_valid, 3);
    chk("wrap_entries_seen", n2, 3);
    chk("wrap_perf_stall", perf_stall2, 32'h0);
    chk("wrap_perf_redirect", perf_redir2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (bits [1:0] SHALL be 0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_addr  output  32  byte address driven to the instruction ROM; equals the internal fetch_pc register.
REQ-005 imem_instr  input  32  ROM read data, combinational from imem_addr in the same cycle.
REQ-006 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-007 redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0).
REQ-008 halt  input  1  level request to stop issuing fetches.
REQ-009 out_valid  output  1  head instruction available to decode.
REQ-010 out_ready  input  1  decode accepts head this cycle (pop when out_valid && out_ready).
REQ-011 out_pc, out_instr  output  32 each  PC and instruction word of the buffer head.
REQ-012 perf_stall_cnt, perf_redirect_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-013 FSM states BOOT, RUN, HALTED; BOOT lasts exactly one cycle after rst deasserts, then RUN (HALTED if halt=1).
REQ-014 RUN->HALTED when halt=1 at a clock edge; HALTED->RUN when halt=0; no fetch issued in BOOT or HALTED.
REQ-015 Instruction buffer is 2 entries of {pc, instr}; count 0..2.
REQ-016 Fetch in RUN: when (count<2) or a pop occurs this cycle, push {fetch_pc, imem_instr} and fetch_pc <= fetch_pc+4.
REQ-017 Pushed entry becomes visible on out_* the next cycle (1-cycle fetch-to-valid latency); simultaneous push and pop at count=2 SHALL keep count=2 with no loss.
REQ-018 out_valid = (count!=0); out_pc/out_instr hold the head entry and are 0 when count=0.
REQ-019 Buffer order is strict FIFO; head unchanged while out_valid && !out_ready.
REQ-020 Redirect has priority over push, pop and halt: in cycle N with redirect_valid=1, at edge N count<=0, fetch_pc<={redirect_pc[31:2],2'b00}, no push, pop ignored.
REQ-021 After redirect in cycle N: out_valid=0 in N+1, target instruction fetched in N+1, out_valid=1 with out_pc=target in N+2 (if RUN).
REQ-022 Redirect in BOOT or HALTED SHALL flush and load fetch_pc without changing state.
REQ-023 fetch_pc increments modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error flag.
REQ-024 Pop on empty buffer (out_ready=1, out_valid=0) SHALL have no effect.

Reset
REQ-025 On rst=1 at a clock edge: state<=BOOT, fetch_pc<=RESET_PC, count<=0, out_valid=0, out_pc=0, out_instr=0, both perf counters<=0.
REQ-026 rst overrides redirect_valid, halt and out_ready in the same cycle; reset mid-operation discards all buffered entries.

Configuration
REQ-027 Macro FETCH_CTRL_PERF_EN: when defined, perf_stall_cnt increments each RUN cycle with count=2 and no pop, and perf_redirect_cnt increments per accepted redirect_valid cycle; both wrap at 2^32.
REQ-028 Without FETCH_CTRL_PERF_EN both perf ports SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the FSM state encoding, buffer depth constant (2), default RESET_PC and instruction width (32).
REQ-030 Buffer SHALL be a sub-module fetch_buf (2-entry FIFO with push, pop, flush, count); fetch_ctrl holds FSM, fetch_pc and counters.

Verification
REQ-031 Reset release, out_ready=1 constant, ROM preloaded -> out_valid first high 2 cycles after BOOT, out_pc sequence 0,4,8,... one per cycle.
REQ-032 out_ready=0 for 5 cycles -> count saturates at 2, fetch_pc stops at 8, out_pc holds 0; perf_stall_cnt=3 with FETCH_CTRL_PERF_EN, 0 without.
REQ-033 redirect_valid=1, redirect_pc=32'h0000_0013 while count=2 -> next cycle out_valid=0, following cycle out_pc=32'h10, perf_redirect_cnt=1.
REQ-034 halt=1 with count=2 then out_ready=1 -> two entries drain, out_valid=0, imem_addr constant; halt=0 -> fetching resumes at held fetch_pc.
REQ-035 RESET_PC=32'hFFFF_FFFC -> out_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-036 rst=1 asserted with count=2 and redirect_valid=1 same cycle -> out_valid=0, imem_addr=RESET_PC next cycle.
